chain_code_decode_controller: RTL

Sequencer that drives `chain_code_decoder` from a chain-code record stored in a byte-wide code memory. On a `go` pulse it:
- fetches the record header and unpacks start coordinates, perimeter and area;
- streams the codes into the decoder with `start` held high, one code per clock;
- waits for `done`, with a watchdog timeout;
- reports a single status word.

It sits between the host/encoder-side code RAM and the decoder.

---
 rtl/chain_code_pkg.sv | 18 +
 rtl/cc_watchdog.sv | 19 +
 rtl/chain_code_decode_controller.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/chain_code_pkg.sv
// chain_code_pkg: shared FSM encoding, status codes, record layout and decoder port widths
package chain_code_pkg;
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_STREAM, S_WAIT, S_REPORT} state_e;
  typedef logic [1:0] status_t;
  localparam status_t ST_OK      = 2'b00;
  localparam status_t ST_DEC_ERR = 2'b01;
  localparam status_t ST_FMT_ERR = 2'b10;
  localparam status_t ST_TIMEOUT = 2'b11;
  localparam int OFF_X    = 0;
  localparam int OFF_Y    = 1;
  localparam int OFF_PLO  = 2;
  localparam int OFF_PHI  = 3;
  localparam int OFF_AREA = 4;
  localparam int HDR_LEN  = 5;
  localparam int PERIM_W  = 9;
  localparam int AREA_W   = 12;
  localparam int COORD_W  = 6;
endpackage

// File: rtl/cc_watchdog.sv
// cc_watchdog: loadable down-counter with clear and enable; expired while the count is zero
module cc_watchdog #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d = clr ? '0 : load ? load_val : (en && cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
  assign expired = cnt_q == '0;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/chain_code_decode_controller.sv
// chain_code_decode_controller: fetches a chain-code record from code memory and streams it
// into chain_code_decoder, reporting one status word per job.
module chain_code_decode_controller
  import chain_code_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 4095
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic [ADDR_W-1:0]  base_addr,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [7:0]         mem_rdata,
  output logic               dec_start,
  output logic [7:0]         dec_code,
  output logic [PERIM_W-1:0] dec_perimeter,
  output logic [AREA_W-1:0]  dec_area,
  output logic [COORD_W-1:0] dec_startX,
  output logic [COORD_W-1:0] dec_startY,
  input  logic               dec_done,
  input  logic               dec_error,
  output logic               busy,
  output logic               job_done,
  output logic [1:0]         job_status
);
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  localparam int IDX_W = 10;
  state_e               state_q, state_d;
  status_t              status_q, status_d, dec_status;
  logic [ADDR_W-1:0]    base_q;
  logic [IDX_W-1:0]     idx_q, ridx_q, last_idx;
  logic                 rvalid_q, start_q, start_d, wd_exp, code_ok, hdr_byte, bad_code;
  logic [7:0]           code_q;
  logic [PERIM_W-1:0]   perim_q;
  logic [AREA_W-1:0]    area_q;
  logic [COORD_W-1:0]   x_q, y_q;
  // idx_q counts issued reads from record byte 0; ridx_q tags the byte now on mem_rdata
  assign last_idx   = IDX_W'(HDR_LEN) + IDX_W'(perim_q) - IDX_W'(1);
  assign mem_rd     = state_q == S_HDR || (state_q == S_STREAM && idx_q <= last_idx);
  assign mem_addr   = base_q + ADDR_W'(idx_q);
  assign code_ok    = rvalid_q && ridx_q >= IDX_W'(HDR_LEN);
  assign hdr_byte   = rvalid_q && ridx_q < IDX_W'(HDR_LEN) && (state_q == S_HDR || state_q == S_STREAM);
  assign bad_code   = mem_rdata[7:3] != '0;
  assign dec_status = dec_error ? ST_DEC_ERR : ST_OK;
  assign busy       = state_q == S_HDR || state_q == S_STREAM || state_q == S_WAIT;
  assign job_done   = state_q == S_REPORT;
  assign job_status = status_q;
  assign dec_start  = start_q;
  assign dec_code   = code_q;
  assign dec_perimeter = perim_q;
  assign dec_area   = area_q;
  assign dec_startX = x_q;
  assign dec_startY = y_q;
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    start_d  = start_q;
    case (state_q)
      S_IDLE: if (go) begin
        state_d  = S_HDR;
        status_d = ST_OK;
      end
      S_HDR: if (rvalid_q && ridx_q == IDX_W'(OFF_PHI)) begin
        state_d = S_STREAM;
        if ({mem_rdata[0], perim_q[7:0]} == '0) begin
          state_d  = S_REPORT;
          status_d = ST_FMT_ERR;
        end
      end
      S_STREAM: if (dec_done) begin
        state_d  = S_REPORT;
        status_d = dec_status;
      end else if (code_ok) begin
        if (bad_code) begin
          state_d  = S_REPORT;
          status_d = ST_FMT_ERR;
        end else begin
          start_d = 1'b1;
          if (ridx_q == last_idx) state_d = S_WAIT;
        end
      end
      S_WAIT: if (dec_done) begin
        state_d  = S_REPORT;
        status_d = dec_status;
      end else if (wd_exp) begin
        state_d  = S_REPORT;
        status_d = ST_TIMEOUT;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_REPORT) start_d = 1'b0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q  <= S_IDLE;
      status_q <= ST_OK;
      start_q  <= 1'b0;
      rvalid_q <= 1'b0;
      ridx_q   <= '0;
      idx_q    <= '0;
      base_q   <= '0;
      code_q   <= '0;
      perim_q  <= '0;
      area_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      start_q  <= start_d;
      rvalid_q <= mem_rd;
      ridx_q   <= idx_q;
      if (state_q == S_IDLE && go) begin
        base_q <= base_addr;
        idx_q  <= '0;
      end else if (mem_rd) idx_q <= idx_q + IDX_W'(1);
      if (hdr_byte)
        case (ridx_q[2:0])
          3'(OFF_X):    x_q <= mem_rdata[COORD_W-1:0];
          3'(OFF_Y):    y_q <= mem_rdata[COORD_W-1:0];
          3'(OFF_PLO):  perim_q[7:0] <= mem_rdata;
          3'(OFF_PHI): begin
            perim_q[8]    <= mem_rdata[0];
            area_q[11:8]  <= mem_rdata[7:4];
          end
          3'(OFF_AREA): area_q[7:0] <= mem_rdata;
          default: ;
        endcase
      if (state_q == S_STREAM && !dec_done && code_ok && !bad_code) code_q <= mem_rdata;
    end
  // loaded with TIMEOUT-1 so the timeout status lands TIMEOUT cycles after the last code
  cc_watchdog #(.W(WD_W)) u_wd (
    .clk      (clk),
    .reset    (reset),
    .clr      (state_q == S_IDLE),
    .load     (state_q == S_STREAM && state_d == S_WAIT),
    .en       (state_q == S_WAIT),
    .load_val (WD_W'(TIMEOUT - 1)),
    .expired  (wd_exp)
  );
endmodule
